// File: rtl/prog_mem_pkg.sv
// -----------------------------------------------------------------------------
// prog_mem_pkg
// Shared definitions for the program memory: controller state encoding,
// default parameter values and the all-zero fill word used by the clear
// sequence.
// -----------------------------------------------------------------------------
package prog_mem_pkg;

    // Controller states: CLEAR walks the array writing zeros, READY serves ports.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_INIT_CLEAR = 1;

    // Wide enough for any supported word width; users slice [DATA_W-1:0].
    localparam int                     ZERO_W_MAX = 1024;
    localparam logic [ZERO_W_MAX-1:0]  ZERO_WORD  = {ZERO_W_MAX{1'b0}};

endpackage : prog_mem_pkg

// File: rtl/prog_mem_addr_chk.sv
// -----------------------------------------------------------------------------
// prog_mem_addr_chk
// Combinational byte-address decode for one memory port.
//   addr_i : byte address
//   idx_o  : word index  addr_i[OFF_W+IDX_W-1:OFF_W]
//   bad_o  : address is misaligned or lies beyond the array
// -----------------------------------------------------------------------------
module prog_mem_addr_chk
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OFF_W  = 2,
    parameter int IDX_W  = 10
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              bad_o
);

    logic misal_s;
    logic high_s;

    assign idx_o = addr_i[OFF_W+IDX_W-1:OFF_W];

    // A byte-wide memory has no offset bits, so it can never be misaligned.
    generate
        if (OFF_W > 0) begin : g_off
            assign misal_s = |addr_i[OFF_W-1:0];
        end else begin : g_no_off
            assign misal_s = 1'b0;
        end

        if (ADDR_W > OFF_W + IDX_W) begin : g_high
            assign high_s = |addr_i[ADDR_W-1:OFF_W+IDX_W];
        end else begin : g_no_high
            assign high_s = 1'b0;
        end
    endgenerate

    assign bad_o = misal_s | high_s;

endmodule : prog_mem_addr_chk

// File: rtl/prog_mem.sv
// -----------------------------------------------------------------------------
// prog_mem
// Single-clock word memory with one read port (request/grant, stallable
// registered output) and one byte-enabled write port. After reset (when
// INIT_CLEAR=1) or on clr_i, the array is zeroed one word per cycle.
//   clk_100MHz / arst         : clock, async active-high reset
//   clr_i                     : start a zero-fill of the array
//   rd_req_i/rd_addr_i/rd_gnt_o/rd_stall_i/rd_vld_o/rd_data_o/rd_err_o : read port
//   wr_ena_i/wr_addr_i/wr_be_i/wr_data_i/wr_err_o                       : write port
//   busy_o                    : clear sequence in progress
// -----------------------------------------------------------------------------
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INIT_CLEAR = DEF_INIT_CLEAR
) (
    input  logic                  clk_100MHz,
    input  logic                  arst,
    input  logic                  clr_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic                  rd_gnt_o,
    input  logic                  rd_stall_i,
    output logic                  rd_vld_o,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_err_o,
    input  logic                  wr_ena_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W/8-1:0]   wr_be_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    output logic                  wr_err_o,
    output logic                  busy_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_DATA = ZERO_WORD[DATA_W-1:0];
    localparam state_e            RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_err_q, rd_err_d;
    logic               wr_err_q, wr_err_d;

    // No reset on the array so it maps onto block RAM.
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [IDX_W-1:0]   rd_idx_s, wr_idx_s;
    logic               rd_bad_s, wr_bad_s;
    logic               ready_s, rd_gnt_s, rd_acc_s, wr_acc_s, rd_hold_s;
    logic [DATA_W-1:0]  wr_word_s, rd_word_s;

    prog_mem_addr_chk #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .IDX_W(IDX_W)) u_rd_chk (
        .addr_i (rd_addr_i),
        .idx_o  (rd_idx_s),
        .bad_o  (rd_bad_s)
    );

    prog_mem_addr_chk #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .IDX_W(IDX_W)) u_wr_chk (
        .addr_i (wr_addr_i),
        .idx_o  (wr_idx_s),
        .bad_o  (wr_bad_s)
    );

    assign ready_s   = (state_q == ST_READY);
    assign rd_hold_s = rd_vld_q & rd_stall_i;
    assign rd_gnt_s  = ready_s & ~rd_hold_s;
    assign rd_acc_s  = rd_req_i & rd_gnt_s;
    assign wr_acc_s  = wr_ena_i & ready_s & ~wr_bad_s;

    // Post-write word for the write index: enabled bytes from wr_data_i, the rest from the array.
    always_comb begin
        wr_word_s = mem_q[wr_idx_s];
        for (int k = 0; k < BE_W; k++) begin
            wr_word_s[k*8 +: 8] = wr_be_i[k] ? wr_data_i[k*8 +: 8] : mem_q[wr_idx_s][k*8 +: 8];
        end
    end

    // Write-first bypass: a read hitting the index written this cycle sees the merged word.
    always_comb begin
        if (wr_acc_s && (wr_idx_s == rd_idx_s)) begin
            rd_word_s = wr_word_s;
        end else begin
            rd_word_s = mem_q[rd_idx_s];
        end
    end

    // Controller next state and clear counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                    cnt_d   = IDX_ZERO;
                end else begin
                    cnt_d   = cnt_q + IDX_ONE;
                end
            end
            ST_READY: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = IDX_ZERO;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = IDX_ZERO;
            end
        endcase
    end

    // Read output next state: hold while stalled, load on accept, otherwise drop valid.
    always_comb begin
        rd_vld_d  = 1'b0;
        rd_data_d = rd_data_q;
        rd_err_d  = 1'b0;
        if (rd_hold_s) begin
            rd_vld_d  = rd_vld_q;
            rd_data_d = rd_data_q;
            rd_err_d  = rd_err_q;
        end else if (rd_acc_s) begin
            rd_vld_d  = 1'b1;
            rd_err_d  = rd_bad_s;
            rd_data_d = rd_bad_s ? ZERO_DATA : rd_word_s;
        end else begin
            rd_vld_d  = 1'b0;
            rd_data_d = rd_data_q;
            rd_err_d  = 1'b0;
        end
    end

    // Any write that was not accepted (bad address or during CLEAR) is flagged next cycle.
    always_comb begin
        wr_err_d = wr_ena_i & ~wr_acc_s;
    end

    // Control and output registers.
    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            state_q   <= RST_STATE;
            cnt_q     <= IDX_ZERO;
            rd_vld_q  <= 1'b0;
            rd_data_q <= ZERO_DATA;
            rd_err_q  <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Array writes: zero fill while clearing, byte-enabled writes while ready.
    always_ff @(posedge clk_100MHz) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= ZERO_DATA;
        end else if (wr_acc_s) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be_i[k]) begin
                    mem_q[wr_idx_s][k*8 +: 8] <= wr_data_i[k*8 +: 8];
                end
            end
        end
    end

    assign rd_gnt_o  = rd_gnt_s;
    assign rd_vld_o  = rd_vld_q;
    assign rd_data_o = rd_data_q;
    assign rd_err_o  = rd_err_q;
    assign wr_err_o  = wr_err_q;
    assign busy_o    = (state_q == ST_CLEAR);

endmodule : prog_mem

// File: tb/tb_prog_mem.sv
// -----------------------------------------------------------------------------
// tb_prog_mem
// Self-checking bench for prog_mem with DEPTH=16, 32-bit words. A plain array
// holds the expected memory contents; read-port behaviour is predicted from
// the port rules (hold on stall, load on request, drop otherwise).
// -----------------------------------------------------------------------------
module tb_prog_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        arst;
    logic        clr_i;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic        rd_stall;
    logic        rd_vld;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        wr_ena;
    logic [31:0] wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    prog_mem #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_CLEAR(1)
    ) dut (
        .clk_100MHz (clk),
        .arst       (arst),
        .clr_i      (clr_i),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_gnt_o   (rd_gnt),
        .rd_stall_i (rd_stall),
        .rd_vld_o   (rd_vld),
        .rd_data_o  (rd_data),
        .rd_err_o   (rd_err),
        .wr_ena_i   (wr_ena),
        .wr_addr_i  (wr_addr),
        .wr_be_i    (wr_be),
        .wr_data_i  (wr_data),
        .wr_err_o   (wr_err),
        .busy_o     (busy)
    );

    // ---------------- reference model ----------------
    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a >= 32'd64);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (addr_bad(a)) return 32'd0;
        return model[a / 32'd4];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        if (!addr_bad(a)) begin
            w = model[a / 32'd4];
            for (int k = 0; k < 4; k++) if (be[k]) w[k*8 +: 8] = d[k*8 +: 8];
            model[a / 32'd4] = w;
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k < DEPTH; k++) model[k] = 32'd0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom % 32'd8;
        if (r == 32'd0) return $urandom;
        if (r == 32'd1) return ($urandom % 32'd64) | 32'd1;
        return ($urandom % 32'd16) * 32'd4;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr_i = 1'b0; rd_req = 1'b0; rd_addr = 32'd0; rd_stall = 1'b0;
        wr_ena = 1'b0; wr_addr = 32'd0; wr_be = 4'd0; wr_data = 32'd0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                            output logic err);
        wr_ena = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        step();
        wr_ena = 1'b0;
        model_write(a, be, d);
        err = wr_err;
    endtask

    task automatic do_read(input logic [31:0] a, output logic v, output logic [31:0] d,
                           output logic e);
        rd_req = 1'b1; rd_addr = a;
        step();
        rd_req = 1'b0;
        v = rd_vld; d = rd_data; e = rd_err;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        logic v, e;
        logic [31:0] d;
        idle();
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", rd_vld); end
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", rd_data); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rd_err); end
        checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        arst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            checks++; if (rd_gnt !== 1'b0) begin failures++; $display("FAIL init_clear_gnt cycle=%0d got=%b exp=0", n, rd_gnt); end
            step();
            n++;
        end
        checks++; if (n != DEPTH) begin failures++; $display("FAIL init_clear_len got=%0d exp=%0d", n, DEPTH); end
        model_zero();
        rd_req = 1'b1; rd_addr = 32'h3C;
        #1;
        checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL ready_gnt got=%b exp=1", rd_gnt); end
        do_read(32'h3C, v, d, e);
        checks++; if (v !== 1'b1 || d !== 32'd0 || e !== 1'b0) begin
            failures++; $display("FAIL read_after_clear got=%b/%h/%b exp=1/0/0", v, d, e); end
    endtask

    task automatic test_byte_enable();
        logic v, e, we;
        logic [31:0] d;
        do_write(32'h8, 4'hF, 32'h11223344, we);
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL be_wr_err1 got=%b exp=0", we); end
        do_write(32'h8, 4'b0101, 32'hAABBCCDD, we);
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL be_wr_err2 got=%b exp=0", we); end
        do_read(32'h8, v, d, e);
        checks++; if (v !== 1'b1 || d !== 32'h11BB33DD || e !== 1'b0) begin
            failures++; $display("FAIL byte_enable got=%b/%h/%b exp=1/11bb33dd/0", v, d, e); end
    endtask

    task automatic test_bad_addr();
        logic v, e, we;
        logic [31:0] d;
        do_read(32'h6, v, d, e);
        checks++; if (v !== 1'b1 || d !== 32'd0 || e !== 1'b1) begin
            failures++; $display("FAIL misaligned_read got=%b/%h/%b exp=1/0/1", v, d, e); end
        do_read(32'h8000_0004, v, d, e);
        checks++; if (v !== 1'b1 || d !== 32'd0 || e !== 1'b1) begin
            failures++; $display("FAIL high_read got=%b/%h/%b exp=1/0/1", v, d, e); end
        for (int k = 0; k < DEPTH; k++) begin
            do_write(32'(k * 4), 4'hF, $urandom, we);
        end
        do_write(32'h40, 4'hF, $urandom, we);
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b exp=1", we); end
        step();
        checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL wr_err_pulse got=%b exp=0", wr_err); end
        do_write(32'h5, 4'hF, $urandom, we);
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL mis_wr_err got=%b exp=1", we); end
        for (int k = 0; k < DEPTH; k++) begin
            do_read(32'(k * 4), v, d, e);
            checks++; if (d !== model_read(32'(k * 4)) || e !== 1'b0) begin
                failures++; $display("FAIL unchanged_word idx=%0d got=%h exp=%h", k, d, model_read(32'(k * 4))); end
        end
    endtask

    task automatic test_stall();
        logic we;
        logic [31:0] r1, r2;
        r1 = $urandom; r2 = $urandom;
        do_write(32'h4, 4'hF, r1, we);
        do_write(32'h8, 4'hF, r2, we);
        rd_req = 1'b1; rd_addr = 32'h4;
        step();
        rd_stall = 1'b1; rd_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rd_gnt !== 1'b0) begin failures++; $display("FAIL stall_gnt cyc=%0d got=%b exp=0", i, rd_gnt); end
            step();
            checks++; if (rd_vld !== 1'b1 || rd_data !== r1 || rd_err !== 1'b0) begin
                failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", i, rd_vld, rd_data, r1); end
        end
        rd_stall = 1'b0;
        #1;
        checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL release_gnt got=%b exp=1", rd_gnt); end
        step();
        rd_req = 1'b0;
        checks++; if (rd_vld !== 1'b1 || rd_data !== r2) begin
            failures++; $display("FAIL release_read got=%b/%h exp=1/%h", rd_vld, rd_data, r2); end
        step();
        checks++; if (rd_vld !== 1'b0 || rd_data !== r2) begin
            failures++; $display("FAIL idle_hold got=%b/%h exp=0/%h", rd_vld, rd_data, r2); end
    endtask

    task automatic test_same_cycle();
        logic [3:0]  be;
        logic [31:0] wd;
        rd_req = 1'b1; rd_addr = 32'h4;
        wr_ena = 1'b1; wr_addr = 32'h4; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        step();
        idle();
        model_write(32'h4, 4'hF, 32'hDEADBEEF);
        checks++; if (rd_vld !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL write_first_full got=%b/%h exp=1/deadbeef", rd_vld, rd_data); end
        be = 4'($urandom); wd = $urandom;
        rd_req = 1'b1; rd_addr = 32'h24;
        wr_ena = 1'b1; wr_addr = 32'h24; wr_be = be; wr_data = wd;
        step();
        idle();
        model_write(32'h24, be, wd);
        checks++; if (rd_data !== model_read(32'h24)) begin
            failures++; $display("FAIL write_first_partial be=%b got=%h exp=%h", be, rd_data, model_read(32'h24)); end
    endtask

    task automatic test_random();
        logic        exp_vld, exp_err, exp_wr_err, exp_gnt;
        logic [31:0] exp_data;
        logic        rq, wr, st;
        logic [31:0] ra, wa, wd;
        logic [3:0]  be;
        idle();
        step();
        exp_vld = 1'b0; exp_err = 1'b0; exp_data = 32'd0;
        for (int i = 0; i < 300; i++) begin
            rq = 1'($urandom % 32'd2); wr = 1'($urandom % 32'd2);
            st = 1'($urandom % 32'd4 == 32'd0);
            ra = pick_addr(); wa = pick_addr(); be = 4'($urandom); wd = $urandom;
            rd_req = rq; rd_addr = ra; rd_stall = st;
            wr_ena = wr; wr_addr = wa; wr_be = be; wr_data = wd;
            #1;
            exp_gnt = !(exp_vld && st);
            checks++; if (rd_gnt !== exp_gnt) begin failures++; $display("FAIL rnd_gnt i=%0d got=%b exp=%b", i, rd_gnt, exp_gnt); end
            if (wr) model_write(wa, be, wd);
            exp_wr_err = wr && addr_bad(wa);
            if (exp_vld && st) begin
                exp_vld = 1'b1;
            end else if (rq) begin
                exp_vld = 1'b1; exp_err = addr_bad(ra); exp_data = model_read(ra);
            end else begin
                exp_vld = 1'b0;
            end
            step();
            checks++; if (rd_vld !== exp_vld) begin failures++; $display("FAIL rnd_vld i=%0d got=%b exp=%b", i, rd_vld, exp_vld); end
            if (exp_vld) begin
                checks++; if (rd_data !== exp_data || rd_err !== exp_err) begin
                    failures++; $display("FAIL rnd_data i=%0d got=%h/%b exp=%h/%b", i, rd_data, rd_err, exp_data, exp_err); end
            end
            checks++; if (wr_err !== exp_wr_err) begin failures++; $display("FAIL rnd_wr_err i=%0d got=%b exp=%b", i, wr_err, exp_wr_err); end
        end
        idle();
        step();
    endtask

    task automatic test_clear();
        int n;
        logic v, e, we;
        logic [31:0] d, x;
        x = $urandom | 32'd1;
        do_write(32'hC, 4'hF, x, we);
        rd_req = 1'b1; rd_addr = 32'hC;
        step();
        rd_req = 1'b0;
        rd_stall = 1'b1; clr_i = 1'b1;
        wr_ena = 1'b1; wr_addr = 32'h14; wr_be = 4'hF; wr_data = $urandom;
        step();
        clr_i = 1'b0; wr_ena = 1'b0;
        checks++; if (wr_err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL clr_entry wr_err/busy got=%b/%b exp=0/1", wr_err, busy); end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            checks++; if (rd_gnt !== 1'b0) begin failures++; $display("FAIL clear_gnt cyc=%0d got=%b exp=0", n, rd_gnt); end
            if (n < 2) begin
                checks++; if (rd_vld !== 1'b1 || rd_data !== x) begin
                    failures++; $display("FAIL clear_stall_hold cyc=%0d got=%b/%h exp=1/%h", n, rd_vld, rd_data, x); end
            end
            if (n == 2) rd_stall = 1'b0;
            if (n == 3) begin
                checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL clear_vld_drop got=%b exp=0", rd_vld); end
            end
            if (n == 4) begin wr_ena = 1'b1; wr_addr = 32'h0; wr_be = 4'hF; wr_data = $urandom | 32'd1; end
            if (n == 5) begin
                wr_ena = 1'b0;
                checks++; if (wr_err !== 1'b1) begin failures++; $display("FAIL clear_wr_err got=%b exp=1", wr_err); end
            end
            if (n == 6) begin
                clr_i = 1'b1;
                checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL clear_wr_err_pulse got=%b exp=0", wr_err); end
            end
            if (n == 7) clr_i = 1'b0;
            step();
            n++;
        end
        idle();
        checks++; if (n != DEPTH) begin failures++; $display("FAIL clear_len got=%0d exp=%0d", n, DEPTH); end
        model_zero();
        for (int k = 0; k < DEPTH; k++) begin
            do_read(32'(k * 4), v, d, e);
            checks++; if (v !== 1'b1 || d !== model_read(32'(k * 4))) begin
                failures++; $display("FAIL cleared_word idx=%0d got=%b/%h exp=1/%h", k, v, d, model_read(32'(k * 4))); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic v, e, we;
        logic [31:0] d, z;
        z = $urandom | 32'h100;
        do_write(32'h4, 4'hF, z, we);
        rd_req = 1'b1; rd_addr = 32'h4;
        step();
        rd_req = 1'b0; rd_stall = 1'b1; clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        repeat (7) step();
        checks++; if (rd_vld !== 1'b1 || rd_data !== z || busy !== 1'b1) begin
            failures++; $display("FAIL pre_arst_hold got=%b/%h/%b exp=1/%h/1", rd_vld, rd_data, busy, z); end
        arst = 1'b1;
        #1;
        checks++; if (rd_vld !== 1'b0 || rd_data !== 32'd0 || rd_err !== 1'b0 || wr_err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL arst_instant got=%b/%h/%b/%b/%b exp=0/0/0/0/1", rd_vld, rd_data, rd_err, wr_err, busy); end
        step();
        arst = 1'b0; rd_stall = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++; if (n != DEPTH) begin failures++; $display("FAIL restart_clear_len got=%0d exp=%0d", n, DEPTH); end
        model_zero();
        do_read(32'h3C, v, d, e);
        checks++; if (v !== 1'b1 || d !== 32'd0 || e !== 1'b0) begin
            failures++; $display("FAIL post_restart_3c got=%b/%h/%b exp=1/0/0", v, d, e); end
        do_read(32'h4, v, d, e);
        checks++; if (v !== 1'b1 || d !== 32'd0) begin
            failures++; $display("FAIL post_restart_4 got=%b/%h exp=1/0", v, d); end
    endtask

    // Bound on total run time in case the design never leaves a wait.
    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        arst = 1'b1;
        test_reset();
        test_byte_enable();
        test_bad_addr();
        test_stall();
        test_same_cycle();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_mem

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning word count (power of 2, >=2).
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-004 SHALL have parameter INIT_CLEAR, default 1, meaning zero-fill memory after reset when 1.
REQ-005 SHALL have clk_100MHz, input, 1, sole clock; all state on its rising edge.
REQ-006 SHALL have arst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have clr_i, input, 1, request to re-zero memory.
REQ-008 SHALL have rd_req_i, input, 1, read request.
REQ-009 SHALL have rd_addr_i, input, ADDR_W, read byte address.
REQ-010 SHALL have rd_gnt_o, output, 1, read accepted this cycle when high with rd_req_i.
REQ-011 SHALL have rd_stall_i, input, 1, consumer cannot take rd_data_o.
REQ-012 SHALL have rd_vld_o, output, 1, rd_data_o/rd_err_o valid.
REQ-013 SHALL have rd_data_o, output, DATA_W, read word.
REQ-014 SHALL have rd_err_o, output, 1, accepted read was misaligned or out of range.
REQ-015 SHALL have wr_ena_i, input, 1, write strobe.
REQ-016 SHALL have wr_addr_i, input, ADDR_W, write byte address.
REQ-017 SHALL have wr_be_i, input, DATA_W/8, byte enables.
REQ-018 SHALL have wr_data_i, input, DATA_W, write word.
REQ-019 SHALL have wr_err_o, output, 1, one-cycle pulse: previous-cycle write rejected.
REQ-020 SHALL have busy_o, output, 1, clear sequence in progress.

Function
REQ-021 OFF_W = log2(DATA_W/8), IDX_W = log2(DEPTH); word index = addr[OFF_W+IDX_W-1:OFF_W].
REQ-022 An address SHALL be bad when addr[OFF_W-1:0] != 0 or any bit above OFF_W+IDX_W-1 is set.
REQ-023 FSM states: CLEAR, READY; reset enters CLEAR if INIT_CLEAR=1, else READY (contents undefined).
REQ-024 CLEAR: zero one word per cycle, index 0..DEPTH-1, via internal counter; go READY the cycle after index DEPTH-1 is written (exactly DEPTH cycles); busy_o=1 throughout.
REQ-025 READY with clr_i=1: enter CLEAR next cycle, counter=0; clr_i ignored while in CLEAR.
REQ-026 rd_gnt_o = (state==READY) and not (rd_vld_o and rd_stall_i); combinational.
REQ-027 Accepted read: rd_vld_o=1 next cycle with mem[index], rd_err_o=0; bad address gives rd_data_o=0, rd_err_o=1.
REQ-028 While rd_vld_o=1 and rd_stall_i=1: rd_vld_o, rd_data_o, rd_err_o held unchanged, including across entry to CLEAR.
REQ-029 No accept and no stall: rd_vld_o=0 next cycle; rd_data_o holds last value.
REQ-030 Back-to-back accepted reads SHALL sustain one word per cycle.
REQ-031 Write in READY, good address: bytes with wr_be_i[k]=1 updated at the edge; others unchanged.
REQ-032 Write with bad address, or any write in CLEAR: no update, wr_err_o=1 the following cycle only.
REQ-033 Same-cycle accepted read and write, same index: read returns the post-write word, merged per byte (write-first).
REQ-034 clr_i and a write in the same READY cycle: write applied, then CLEAR begins.

Reset
REQ-035 arst=1 SHALL immediately force rd_vld_o=0, rd_err_o=0, rd_data_o=0, wr_err_o=0, counter=0; busy_o=INIT_CLEAR.
REQ-036 Reset mid-clear or mid-read SHALL abandon the operation; clear restarts from index 0 after release.
REQ-037 Memory array itself SHALL have no reset (block-RAM inferable); zeroing only via CLEAR.

Structure
REQ-038 State encoding, default parameter values and ZERO_WORD SHALL live in the shared define package.
REQ-039 One sub-module, prog_mem_addr_chk (combinational index/bad-flag decode), SHALL be instantiated twice, once per port.

Verification
REQ-040 Reset release, INIT_CLEAR=1, DEPTH=16: busy_o=1 for 16 cycles, rd_gnt_o=0; then read 0x3C -> rd_data_o=0, rd_vld_o=1.
REQ-041 Write 0x8 data 0xAABBCCDD be=0101, prior word 0x11223344 -> read 0x8 returns 0x11BB33DD.
REQ-042 Read 0x6 -> rd_err_o=1, rd_data_o=0; write 0x40 (DEPTH=16) -> wr_err_o pulses one cycle, no word changes.
REQ-043 Read 0x4 with rd_stall_i=1 for 3 cycles -> rd_vld_o and data held 3 cycles, rd_gnt_o=0 throughout, next read accepted on release.
REQ-044 Same cycle: write 0x4 = 0xDEADBEEF be=1111, read 0x4 -> rd_data_o=0xDEADBEEF next cycle.
REQ-045 arst pulse at clear index 7 -> outputs zeroed instantly; clear restarts at 0, busy_o=1 for full 16 cycles.
